// File: rtl/encoder_txrx_sm.sv
// Simplified 1000BASE-T style PCS: TX framing FSM, side-stream scrambler,
// 4-lane PAM5 symbol encoder and RX framing FSM with collision detect.
module encoder_txrx_sm #(
   parameter logic [32:0] SEED = 33'h1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       io_tx_enable,
   input  logic       io_tx_mode,
   input  logic       io_tx_error,
   input  logic [7:0] io_txd,
   input  logic       io_symb_timer_done,
   input  logic [31:0] io_n,
   input  logic [31:0] io_n0,
   input  logic       io_loc_rcvr_status,
   input  logic       io_rx_symb_vector_valid,
   input  logic [2:0] io_rx_symb_vector_bits_0,
   input  logic [2:0] io_rx_symb_vector_bits_1,
   input  logic [2:0] io_rx_symb_vector_bits_2,
   input  logic [2:0] io_rx_symb_vector_bits_3,
   input  logic [7:0] io_decoded_rx_symb_vector,
   input  logic       io_pcs_reset,
   output logic [7:0] io_rxd,
   output logic       io_rx_dv,
   output logic       io_rx_er,
   output logic       io_rxerror_status,
   output logic       io_rx_symb_vector_ready,
   output logic       io_col,
   input  logic       io_tx_symb_vector_ready,
   output logic       io_tx_symb_vector_valid,
   output logic [2:0] io_tx_symb_vector_bits_0,
   output logic [2:0] io_tx_symb_vector_bits_1,
   output logic [2:0] io_tx_symb_vector_bits_2,
   output logic [2:0] io_tx_symb_vector_bits_3
);

   typedef enum logic [2:0] {
      TX_IDLE = 3'd0,
      TX_SSD1 = 3'd1,
      TX_SSD2 = 3'd2,
      TX_DATA = 3'd3,
      TX_ESD1 = 3'd4,
      TX_ESD2 = 3'd5
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE     = 2'd0,
      RX_SSD_SEEN = 2'd1,
      RX_RECEIVE  = 2'd2,
      RX_ESD_SEEN = 2'd3
   } rx_state_t;

   localparam logic [2:0] SYM_P2 = 3'b010;
   localparam logic [2:0] SYM_P1 = 3'b001;
   localparam logic [2:0] SYM_Z  = 3'b000;
   localparam logic [2:0] SYM_M1 = 3'b111;
   localparam logic [2:0] SYM_M2 = 3'b110;

   // Vectors are packed {A, B, C, D} with lane A in the top three bits.
   localparam logic [11:0] VEC_SSD1 = {SYM_P2, SYM_Z, SYM_P2, SYM_Z};
   localparam logic [11:0] VEC_SSD2 = {SYM_Z, SYM_P2, SYM_Z, SYM_P2};
   localparam logic [11:0] VEC_ESD1 = {SYM_M2, SYM_Z, SYM_M2, SYM_Z};
   localparam logic [11:0] VEC_ESD2 = {SYM_Z, SYM_M2, SYM_Z, SYM_M2};
   localparam logic [11:0] VEC_ERR  = {SYM_Z, SYM_Z, SYM_P2, SYM_P2};

   function automatic logic [2:0] pam_map(input logic [1:0] pair);
      logic [2:0] sym;
      case (pair)
         2'b00:   sym = SYM_M2;
         2'b01:   sym = SYM_M1;
         2'b10:   sym = SYM_P1;
         2'b11:   sym = SYM_P2;
         default: sym = SYM_M2;
      endcase
      return sym;
   endfunction

   function automatic logic is_bad_sym(input logic [2:0] sym);
      logic bad;
      case (sym)
         3'b011, 3'b100, 3'b101: bad = 1'b1;
         default:                bad = 1'b0;
      endcase
      return bad;
   endfunction

   tx_state_t   tx_state_r;
   tx_state_t   tx_next_s;
   rx_state_t   rx_state_r;
   logic [32:0] scr_r;
   logic [32:0] scr_next_s;
   logic [11:0] tx_vec_r;
   logic [11:0] tx_vec_s;
   logic [11:0] idle_vec_s;
   logic [7:0]  data_s;
   logic        tx_valid_r;
   logic        rx_ready_r;
   logic        tx_accept_s;
   logic [11:0] rx_vec_s;
   logic        rx_fire_s;
   logic        rx_bad_s;
   logic        rx_err_set_s;
   logic [7:0]  rxd_r;
   logic        rx_dv_r;
   logic        rx_er_r;
   logic        rxerr_status_r;

   // Next TX vector, next TX state and next scrambler value.
   always_comb begin
      tx_accept_s = tx_valid_r & io_tx_symb_vector_ready;
      data_s      = io_txd ^ scr_r[7:0];
      if (io_n == io_n0) begin
         scr_next_s = SEED;
      end else begin
         scr_next_s = {scr_r[31:0], scr_r[32] ^ scr_r[12]};
      end
      idle_vec_s = {scr_r[0] ? SYM_P2 : SYM_M2,
                    scr_r[1] ? SYM_P2 : SYM_M2,
                    scr_r[2] ? SYM_P2 : SYM_M2,
                    (scr_r[3] ^ io_loc_rcvr_status) ? SYM_P2 : SYM_M2};
      tx_vec_s  = 12'h000;
      tx_next_s = tx_state_r;
      if (io_tx_mode) begin
         tx_vec_s  = 12'h000;
         tx_next_s = TX_IDLE;
      end else begin
         case (tx_state_r)
            TX_IDLE: begin
               tx_vec_s = idle_vec_s;
               if (io_tx_enable) tx_next_s = TX_SSD1;
               else              tx_next_s = TX_IDLE;
            end
            TX_SSD1: begin
               tx_vec_s  = VEC_SSD1;
               tx_next_s = TX_SSD2;
            end
            TX_SSD2: begin
               tx_vec_s  = VEC_SSD2;
               tx_next_s = TX_DATA;
            end
            TX_DATA: begin
               if (io_tx_error) begin
                  tx_vec_s = VEC_ERR;
               end else begin
                  tx_vec_s = {pam_map(data_s[1:0]), pam_map(data_s[3:2]),
                              pam_map(data_s[5:4]), pam_map(data_s[7:6])};
               end
               if (io_tx_enable) tx_next_s = TX_DATA;
               else              tx_next_s = TX_ESD1;
            end
            TX_ESD1: begin
               tx_vec_s  = VEC_ESD1;
               tx_next_s = TX_ESD2;
            end
            TX_ESD2: begin
               tx_vec_s  = VEC_ESD2;
               tx_next_s = TX_IDLE;
            end
            default: begin
               tx_vec_s  = 12'h000;
               tx_next_s = TX_IDLE;
            end
         endcase
      end
   end

   // TX FSM, scrambler and registered symbol output; all move only on accept.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_state_r <= TX_IDLE;
         scr_r      <= SEED;
         tx_vec_r   <= 12'h000;
         tx_valid_r <= 1'b0;
      end else if (io_pcs_reset) begin
         tx_state_r <= TX_IDLE;
         scr_r      <= SEED;
         tx_vec_r   <= 12'h000;
         tx_valid_r <= 1'b0;
      end else begin
         tx_valid_r <= 1'b1;
         if (tx_accept_s) begin
            tx_state_r <= tx_next_s;
            scr_r      <= scr_next_s;
            tx_vec_r   <= tx_vec_s;
         end
      end
   end

   // Decode of the received vector into fire/error conditions.
   always_comb begin
      rx_vec_s  = {io_rx_symb_vector_bits_0, io_rx_symb_vector_bits_1,
                   io_rx_symb_vector_bits_2, io_rx_symb_vector_bits_3};
      rx_fire_s = rx_ready_r & io_rx_symb_vector_valid;
      rx_bad_s  = is_bad_sym(io_rx_symb_vector_bits_0) | is_bad_sym(io_rx_symb_vector_bits_1) |
                  is_bad_sym(io_rx_symb_vector_bits_2) | is_bad_sym(io_rx_symb_vector_bits_3);
      rx_err_set_s = rx_fire_s & (rx_state_r == RX_RECEIVE) & (rx_vec_s != VEC_ESD1) & rx_bad_s;
   end

   // RX FSM with registered rxd/rx_dv/rx_er and sticky error status.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_state_r     <= RX_IDLE;
         rx_ready_r     <= 1'b0;
         rxd_r          <= 8'h00;
         rx_dv_r        <= 1'b0;
         rx_er_r        <= 1'b0;
         rxerr_status_r <= 1'b0;
      end else if (io_pcs_reset) begin
         rx_state_r     <= RX_IDLE;
         rx_ready_r     <= 1'b0;
         rxd_r          <= 8'h00;
         rx_dv_r        <= 1'b0;
         rx_er_r        <= 1'b0;
         rxerr_status_r <= 1'b0;
      end else begin
         rx_ready_r <= 1'b1;
         rx_dv_r    <= 1'b0;
         rx_er_r    <= 1'b0;
         if (rx_fire_s) begin
            case (rx_state_r)
               RX_IDLE: begin
                  if (rx_vec_s == VEC_SSD1) rx_state_r <= RX_SSD_SEEN;
               end
               RX_SSD_SEEN: begin
                  if (rx_vec_s == VEC_SSD2) rx_state_r <= RX_RECEIVE;
                  else                      rx_state_r <= RX_IDLE;
               end
               RX_RECEIVE: begin
                  if (rx_vec_s == VEC_ESD1) begin
                     rx_state_r <= RX_ESD_SEEN;
                  end else begin
                     rxd_r   <= io_decoded_rx_symb_vector;
                     rx_dv_r <= 1'b1;
                     rx_er_r <= rx_bad_s;
                  end
               end
               RX_ESD_SEEN: rx_state_r <= RX_IDLE;
               default:     rx_state_r <= RX_IDLE;
            endcase
         end
         if (rx_err_set_s)            rxerr_status_r <= 1'b1;
         else if (io_symb_timer_done) rxerr_status_r <= 1'b0;
      end
   end

   assign io_tx_symb_vector_valid  = tx_valid_r;
   assign io_tx_symb_vector_bits_0 = tx_vec_r[11:9];
   assign io_tx_symb_vector_bits_1 = tx_vec_r[8:6];
   assign io_tx_symb_vector_bits_2 = tx_vec_r[5:3];
   assign io_tx_symb_vector_bits_3 = tx_vec_r[2:0];
   assign io_rx_symb_vector_ready  = rx_ready_r;
   assign io_rxd                   = rxd_r;
   assign io_rx_dv                 = rx_dv_r;
   assign io_rx_er                 = rx_er_r;
   assign io_rxerror_status        = rxerr_status_r;
   assign io_col                   = (tx_state_r != TX_IDLE) & rx_dv_r;

endmodule

// File: tb/tb_encoder_txrx_sm.sv
// Self-checking bench for encoder_txrx_sm: directed plan steps followed by
// randomized traffic, compared against a symbol-level reference model.
module tb_encoder_txrx_sm;

   localparam logic [32:0] SEED = 33'h1;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic tx_enable = 1'b0, tx_mode = 1'b0, tx_error = 1'b0;
   logic [7:0] txd = 8'h00;
   logic symb_timer_done = 1'b0;
   logic [31:0] n = 32'd1, n0 = 32'd0;
   logic loc_rcvr_status = 1'b1;
   logic rx_valid = 1'b0;
   logic [2:0] rb0 = 3'b000, rb1 = 3'b000, rb2 = 3'b000, rb3 = 3'b000;
   logic [7:0] decoded = 8'h00;
   logic pcs_reset = 1'b0;
   logic tx_ready = 1'b0;
   logic [7:0] rxd;
   logic rx_dv, rx_er, rxerror_status, rx_ready, col, tx_valid;
   logic [2:0] tb0, tb1, tb2, tb3;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int          m_tx_phase;   // 0 idle, 1 ssd1, 2 ssd2, 3 data, 4 esd1, 5 esd2
   logic [32:0] m_scr;
   int          m_a, m_b, m_c, m_d;
   bit          m_valid, m_rdy;
   int          m_rx_phase;   // 0 idle, 1 ssd seen, 2 receive, 3 esd seen
   logic [7:0]  m_rxd;
   bit          m_dv, m_er, m_st;

   encoder_txrx_sm #(.SEED(SEED)) dut (
      .clock(clock), .reset(reset),
      .io_tx_enable(tx_enable), .io_tx_mode(tx_mode), .io_tx_error(tx_error),
      .io_txd(txd), .io_symb_timer_done(symb_timer_done),
      .io_n(n), .io_n0(n0), .io_loc_rcvr_status(loc_rcvr_status),
      .io_rx_symb_vector_valid(rx_valid),
      .io_rx_symb_vector_bits_0(rb0), .io_rx_symb_vector_bits_1(rb1),
      .io_rx_symb_vector_bits_2(rb2), .io_rx_symb_vector_bits_3(rb3),
      .io_decoded_rx_symb_vector(decoded), .io_pcs_reset(pcs_reset),
      .io_rxd(rxd), .io_rx_dv(rx_dv), .io_rx_er(rx_er),
      .io_rxerror_status(rxerror_status), .io_rx_symb_vector_ready(rx_ready),
      .io_col(col), .io_tx_symb_vector_ready(tx_ready),
      .io_tx_symb_vector_valid(tx_valid),
      .io_tx_symb_vector_bits_0(tb0), .io_tx_symb_vector_bits_1(tb1),
      .io_tx_symb_vector_bits_2(tb2), .io_tx_symb_vector_bits_3(tb3)
   );

   always #5 clock = ~clock;

   function automatic int sx(input logic [2:0] v);
      return int'($signed(v));
   endfunction

   // PAM5 level of a 2-bit pair: 0,1,2,3 -> -2,-1,+1,+2
   function automatic int map2(input logic [1:0] p);
      int v;
      v = int'(p);
      return (v < 2) ? v - 2 : v - 1;
   endfunction

   function automatic bit bad_level(input int v);
      return (v == 3) || (v == -3) || (v == -4);
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_tx_phase = 0; m_scr = SEED;
      m_a = 0; m_b = 0; m_c = 0; m_d = 0;
      m_valid = 0; m_rdy = 0;
      m_rx_phase = 0; m_rxd = 8'h00;
      m_dv = 0; m_er = 0; m_st = 0;
   endtask

   task automatic check_all();
      chk("tx_valid", int'(tx_valid), int'(m_valid));
      chk("rx_ready", int'(rx_ready), int'(m_rdy));
      chk("tx_a", sx(tb0), m_a);
      chk("tx_b", sx(tb1), m_b);
      chk("tx_c", sx(tb2), m_c);
      chk("tx_d", sx(tb3), m_d);
      chk("rxd", int'(rxd), int'(m_rxd));
      chk("rx_dv", int'(rx_dv), int'(m_dv));
      chk("rx_er", int'(rx_er), int'(m_er));
      chk("rxerror_status", int'(rxerror_status), int'(m_st));
      chk("col", int'(col), int'((m_tx_phase != 0) && m_dv));
   endtask

   task automatic set_vec(input int a, input int b, input int c, input int d);
      m_a = a; m_b = b; m_c = c; m_d = d;
   endtask

   // Advance the model with the current inputs, clock once, compare.
   task automatic tick();
      int ra, rb, rc, rd;
      logic [7:0] dd;
      bit bad;
      if (pcs_reset) begin
         model_reset();
      end else begin
         if (m_valid && tx_ready) begin
            if (tx_mode) begin
               set_vec(0, 0, 0, 0);
               m_tx_phase = 0;
            end else begin
               case (m_tx_phase)
                  0: begin
                     set_vec(m_scr[0] ? 2 : -2, m_scr[1] ? 2 : -2, m_scr[2] ? 2 : -2,
                             (m_scr[3] ^ loc_rcvr_status) ? 2 : -2);
                     if (tx_enable) m_tx_phase = 1;
                  end
                  1: begin set_vec(2, 0, 2, 0); m_tx_phase = 2; end
                  2: begin set_vec(0, 2, 0, 2); m_tx_phase = 3; end
                  3: begin
                     if (tx_error) set_vec(0, 0, 2, 2);
                     else begin
                        dd = txd ^ m_scr[7:0];
                        set_vec(map2(dd[1:0]), map2(dd[3:2]), map2(dd[5:4]), map2(dd[7:6]));
                     end
                     m_tx_phase = tx_enable ? 3 : 4;
                  end
                  4: begin set_vec(-2, 0, -2, 0); m_tx_phase = 5; end
                  default: begin set_vec(0, -2, 0, -2); m_tx_phase = 0; end
               endcase
            end
            m_scr = (n == n0) ? SEED : {m_scr[31:0], m_scr[32] ^ m_scr[12]};
         end
         m_valid = 1;
         m_dv = 0; m_er = 0;
         if (m_rdy && rx_valid) begin
            ra = sx(rb0); rb = sx(rb1); rc = sx(rb2); rd = sx(rb3);
            bad = bad_level(ra) || bad_level(rb) || bad_level(rc) || bad_level(rd);
            case (m_rx_phase)
               0: if (ra == 2 && rb == 0 && rc == 2 && rd == 0) m_rx_phase = 1;
               1: m_rx_phase = (ra == 0 && rb == 2 && rc == 0 && rd == 2) ? 2 : 0;
               2: begin
                  if (ra == -2 && rb == 0 && rc == -2 && rd == 0) m_rx_phase = 3;
                  else begin
                     m_dv = 1; m_rxd = decoded; m_er = bad;
                  end
               end
               default: m_rx_phase = 0;
            endcase
         end
         if (m_er) m_st = 1;
         else if (symb_timer_done) m_st = 0;
         m_rdy = 1;
      end
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic rx_vec(input int a, input int b, input int c, input int d, input logic [7:0] dec);
      rx_valid = 1'b1;
      rb0 = 3'(a); rb1 = 3'(b); rb2 = 3'(c); rb3 = 3'(d);
      decoded = dec;
   endtask

   initial begin
      int r;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check_all();
      reset = 1'b1;
      tx_ready = 1'b1;

      // Step 1: first accepted vector is idle with s = SEED
      tick();
      tick();
      chk("idle_a_bits", int'(tb0), 2);
      chk("idle_b_bits", int'(tb1), 6);
      chk("idle_c_bits", int'(tb2), 6);
      chk("idle_d_bits", int'(tb3), 2);

      // Step 2/4: SSD1, SSD2, data, one ERR vector
      tx_enable = 1'b1;
      tick();
      tick();
      chk("ssd1_bits", int'({tb0, tb1, tb2, tb3}), int'(12'b010_000_010_000));
      tick();
      chk("ssd2_bits", int'({tb0, tb1, tb2, tb3}), int'(12'b000_010_000_010));
      for (int i = 0; i < 4; i++) begin
         txd = 8'(i);
         tick();
         chk("data_nonzero", int'(tb0 != 3'b000 && tb1 != 3'b000 && tb2 != 3'b000 && tb3 != 3'b000), 1);
      end
      tx_error = 1'b1; txd = 8'h04;
      tick();
      chk("err_bits", int'({tb0, tb1, tb2, tb3}), int'(12'b000_000_010_010));
      tx_error = 1'b0; txd = 8'h05;
      tick();
      chk("after_err_nonzero", int'(tb0 != 3'b000 && tb2 != 3'b000), 1);

      // Step 3: drop enable, ESD1/ESD2, idle, then stall
      tx_enable = 1'b0; txd = 8'h06;
      tick();
      tick();
      chk("esd1_bits", int'({tb0, tb1, tb2, tb3}), int'(12'b110_000_110_000));
      tick();
      chk("esd2_bits", int'({tb0, tb1, tb2, tb3}), int'(12'b000_110_000_110));
      tick();
      tx_ready = 1'b0;
      repeat (5) tick();
      tx_ready = 1'b1;

      // Step 5: RX frame and error symbol
      rx_vec(2, 0, 2, 0, 8'h00); tick();
      rx_vec(0, 2, 0, 2, 8'h00); tick();
      rx_vec(1, -1, 2, -2, 8'hA5); tick();
      chk("rx_dv_1", int'(rx_dv), 1);
      chk("rxd_1", int'(rxd), 'hA5);
      rx_vec(1, -1, 2, -2, 8'h5A); tick();
      chk("rxd_2", int'(rxd), 'h5A);
      rx_vec(1, -1, 2, -2, 8'h3C); tick();
      chk("rxd_3", int'(rxd), 'h3C);
      rx_vec(-2, 0, -2, 0, 8'h00); tick();
      chk("rx_dv_esd", int'(rx_dv), 0);
      rx_vec(0, 0, 0, 0, 8'h00); tick();
      rx_vec(2, 0, 2, 0, 8'h00); tick();
      rx_vec(0, 2, 0, 2, 8'h00); tick();
      rx_vec(3, 0, 0, 0, 8'h11); tick();
      chk("rx_er_set", int'(rx_er), 1);
      chk("status_set", int'(rxerror_status), 1);
      rx_valid = 1'b0; tick();
      chk("status_sticky", int'(rxerror_status), 1);
      symb_timer_done = 1'b1; tick();
      chk("status_clear", int'(rxerror_status), 0);
      symb_timer_done = 1'b0;
      rx_vec(-2, 0, -2, 0, 8'h00); tick();
      rx_vec(0, 0, 0, 0, 8'h00); tick();

      // Step 6: collision, then tx_mode zeros
      tx_enable = 1'b1;
      rx_vec(2, 0, 2, 0, 8'h00); tick();
      rx_vec(0, 2, 0, 2, 8'h00); tick();
      rx_vec(1, 1, 1, 1, 8'h77); tick();
      chk("col_active", int'(col), 1);
      tx_mode = 1'b1; tick();
      chk("mode_zero", int'({tb0, tb1, tb2, tb3}), 0);
      tx_mode = 1'b0; tx_enable = 1'b0; rx_valid = 1'b0;
      pcs_reset = 1'b1; tick();
      pcs_reset = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) tx_enable = ~tx_enable;
         tx_error  = ($urandom_range(0, 7) == 0);
         tx_mode   = ($urandom_range(0, 31) == 0);
         tx_ready  = ($urandom_range(0, 4) != 0);
         txd       = 8'($urandom);
         loc_rcvr_status = 1'($urandom);
         n0 = 32'($urandom_range(0, 1000));
         n  = ($urandom_range(0, 15) == 0) ? n0 : n0 + 32'd1;
         symb_timer_done = ($urandom_range(0, 15) == 0);
         pcs_reset = ($urandom_range(0, 99) == 0);
         r = $urandom_range(0, 9);
         if (r == 0)      rx_vec(2, 0, 2, 0, 8'($urandom));
         else if (r == 1) rx_vec(0, 2, 0, 2, 8'($urandom));
         else if (r == 2) rx_vec(-2, 0, -2, 0, 8'($urandom));
         else if (r == 3) rx_valid = 1'b0;
         else begin
            rx_valid = 1'b1;
            rb0 = 3'($urandom); rb1 = 3'($urandom); rb2 = 3'($urandom); rb3 = 3'($urandom);
            decoded = 8'($urandom);
         end
         tick();
      end
      pcs_reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
